// File: rtl/reg_file_bank.sv
// Parametrised register file: DEPTH x WIDTH storage, one synchronous write
// port, two registered read ports with optional write bypass, an optional
// hard-wired zero register and a one-entry-per-cycle clear sequencer.
module reg_file_bank #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 2,
  parameter bit BYPASS    = 1'b1,
  parameter bit ZERO_REG0 = 1'b0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              WriteEnable,
  input  logic [ADDR_W-1:0] WriteSelect,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              ReadEnable,
  input  logic [ADDR_W-1:0] ReadSelectA,
  input  logic [ADDR_W-1:0] ReadSelectB,
  output logic [WIDTH-1:0]  ReadDataA,
  output logic [WIDTH-1:0]  ReadDataB,
  output logic              ReadValid,
  input  logic              ClearReq,
  output logic              Busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_idx, clr_idx_next;
  logic [WIDTH-1:0]  regs [DEPTH];
  logic              busy_int;
  logic              write_ok;
  logic              read_ok;
  logic [WIDTH-1:0]  rd_a, rd_b;

  // A write lands only when idle, in range and not aimed at a hard-wired zero
  always_comb begin
    write_ok = 1'b0;
    if (WriteEnable && !busy_int && (32'(WriteSelect) < 32'(DEPTH)))
      write_ok = 1'b1;
    if (ZERO_REG0 && (WriteSelect == '0))
      write_ok = 1'b0;
  end

  assign read_ok = ReadEnable && !busy_int;

  // Read muxes: out-of-range selects fall through to zero, bypass forwards only accepted writes
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ReadSelectA == ADDR_W'(i)) rd_a = regs[i];
      if (ReadSelectB == ADDR_W'(i)) rd_b = regs[i];
    end
    if (BYPASS && write_ok && (ReadSelectA == WriteSelect)) rd_a = WriteData;
    if (BYPASS && write_ok && (ReadSelectB == WriteSelect)) rd_b = WriteData;
    if (ZERO_REG0 && (ReadSelectA == '0)) rd_a = '0;
    if (ZERO_REG0 && (ReadSelectB == '0)) rd_b = '0;
  end

  // Storage update: the clear sequencer wipes one entry per cycle, otherwise accepted writes land
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((state == CLEAR) && (clr_idx == ADDR_W'(i)))
          regs[i] <= '0;
        else if (write_ok && (WriteSelect == ADDR_W'(i)))
          regs[i] <= WriteData;
      end
    end
  end

  // Registered read ports: update and flag valid on an accepted read, hold otherwise
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ReadDataA <= '0;
      ReadDataB <= '0;
      ReadValid <= 1'b0;
    end else begin
      ReadValid <= read_ok;
      if (read_ok) begin
        ReadDataA <= rd_a;
        ReadDataB <= rd_b;
      end
    end
  end

  // Clear sequencer state and index register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      clr_idx <= '0;
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
    end
  end

  // Clear sequencer next state: walk index 0..DEPTH-1 then return to idle
  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    case (state)
      IDLE: begin
        if (ClearReq) begin
          state_next   = CLEAR;
          clr_idx_next = '0;
        end
      end
      CLEAR: begin
        if (clr_idx == ADDR_W'(DEPTH - 1)) begin
          state_next   = IDLE;
          clr_idx_next = '0;
        end else begin
          clr_idx_next = clr_idx + 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        clr_idx_next = '0;
      end
    endcase
  end

  // Clear sequencer outputs: busy is a decode of the registered state
  always_comb begin
    busy_int = (state == CLEAR);
  end

  assign Busy = busy_int;

endmodule

// File: tb/tb_reg_file_bank.sv
// Directed testbench for reg_file_bank. Three instances share the inputs:
// the default build (BYPASS=1, DEPTH=4), a no-bypass build and a
// zero-register build with DEPTH=3 so address 3 is out of range.
module tb_reg_file_bank;

  logic        CLK;
  logic        RESET_N;
  logic        WriteEnable;
  logic [1:0]  WriteSelect;
  logic [15:0] WriteData;
  logic        ReadEnable;
  logic [1:0]  ReadSelectA;
  logic [1:0]  ReadSelectB;
  logic        ClearReq;

  logic [15:0] rda, rdb, nb_rda, nb_rdb, z_rda, z_rdb;
  logic        rv, busy, nb_rv, nb_busy, z_rv, z_busy;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file_bank #(.WIDTH(16), .DEPTH(4), .ADDR_W(2), .BYPASS(1'b1), .ZERO_REG0(1'b0)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .WriteEnable(WriteEnable), .WriteSelect(WriteSelect),
    .WriteData(WriteData), .ReadEnable(ReadEnable), .ReadSelectA(ReadSelectA),
    .ReadSelectB(ReadSelectB), .ReadDataA(rda), .ReadDataB(rdb), .ReadValid(rv),
    .ClearReq(ClearReq), .Busy(busy));

  reg_file_bank #(.WIDTH(16), .DEPTH(4), .ADDR_W(2), .BYPASS(1'b0), .ZERO_REG0(1'b0)) dut_nb (
    .CLK(CLK), .RESET_N(RESET_N), .WriteEnable(WriteEnable), .WriteSelect(WriteSelect),
    .WriteData(WriteData), .ReadEnable(ReadEnable), .ReadSelectA(ReadSelectA),
    .ReadSelectB(ReadSelectB), .ReadDataA(nb_rda), .ReadDataB(nb_rdb), .ReadValid(nb_rv),
    .ClearReq(ClearReq), .Busy(nb_busy));

  reg_file_bank #(.WIDTH(16), .DEPTH(3), .ADDR_W(2), .BYPASS(1'b1), .ZERO_REG0(1'b1)) dut_z (
    .CLK(CLK), .RESET_N(RESET_N), .WriteEnable(WriteEnable), .WriteSelect(WriteSelect),
    .WriteData(WriteData), .ReadEnable(ReadEnable), .ReadSelectA(ReadSelectA),
    .ReadSelectB(ReadSelectB), .ReadDataA(z_rda), .ReadDataB(z_rdb), .ReadValid(z_rv),
    .ClearReq(ClearReq), .Busy(z_busy));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    WriteEnable = 1'b0; WriteSelect = '0; WriteData = '0;
    ReadEnable  = 1'b0; ReadSelectA = '0; ReadSelectB = '0;
    ClearReq    = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] sel, input logic [15:0] data);
    idle_inputs();
    WriteEnable = 1'b1; WriteSelect = sel; WriteData = data;
    tick();
    idle_inputs();
  endtask

  task automatic do_read(input logic [1:0] a, input logic [1:0] b);
    idle_inputs();
    ReadEnable = 1'b1; ReadSelectA = a; ReadSelectB = b;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    idle_inputs();
    tick(); tick();
    n_checks++; if (rda !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_rda actual=%h expected=0000", rda); end
    n_checks++; if (rv !== 1'b0)      begin n_fail++; $display("[TB] FAIL reset_rv actual=%b expected=0", rv); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("[TB] FAIL reset_busy actual=%b expected=0", busy); end
    RESET_N = 1'b1;
    tick();
    do_read(2'd1, 2'd3);
    n_checks++; if (rda !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_read_a actual=%h expected=0000", rda); end
    n_checks++; if (rdb !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_read_b actual=%h expected=0000", rdb); end
    n_checks++; if (rv !== 1'b1)      begin n_fail++; $display("[TB] FAIL reset_read_valid actual=%b expected=1", rv); end
    tick();
    n_checks++; if (rv !== 1'b0)      begin n_fail++; $display("[TB] FAIL reset_valid_drop actual=%b expected=0", rv); end
  endtask

  task automatic test_write_read();
    do_write(2'd2, 16'hBEEF);
    do_write(2'd3, 16'h1234);
    do_read(2'd2, 2'd3);
    n_checks++; if (rda !== 16'hBEEF) begin n_fail++; $display("[TB] FAIL wr_read_a actual=%h expected=beef", rda); end
    n_checks++; if (rdb !== 16'h1234) begin n_fail++; $display("[TB] FAIL wr_read_b actual=%h expected=1234", rdb); end
    n_checks++; if (rv !== 1'b1)      begin n_fail++; $display("[TB] FAIL wr_read_valid actual=%b expected=1", rv); end
    ReadSelectA = 2'd0; ReadSelectB = 2'd1;
    tick();
    n_checks++; if (rda !== 16'hBEEF) begin n_fail++; $display("[TB] FAIL hold_a actual=%h expected=beef", rda); end
    n_checks++; if (rdb !== 16'h1234) begin n_fail++; $display("[TB] FAIL hold_b actual=%h expected=1234", rdb); end
    n_checks++; if (rv !== 1'b0)      begin n_fail++; $display("[TB] FAIL hold_valid actual=%b expected=0", rv); end
  endtask

  task automatic test_bypass();
    do_write(2'd1, 16'h5555);
    WriteEnable = 1'b1; WriteSelect = 2'd1; WriteData = 16'hAAAA;
    ReadEnable  = 1'b1; ReadSelectA = 2'd1; ReadSelectB = 2'd1;
    tick();
    idle_inputs();
    n_checks++; if (rda !== 16'hAAAA)    begin n_fail++; $display("[TB] FAIL bypass_a actual=%h expected=aaaa", rda); end
    n_checks++; if (rdb !== 16'hAAAA)    begin n_fail++; $display("[TB] FAIL bypass_b actual=%h expected=aaaa", rdb); end
    n_checks++; if (nb_rda !== 16'h5555) begin n_fail++; $display("[TB] FAIL nobypass_a actual=%h expected=5555", nb_rda); end
    n_checks++; if (z_rda !== 16'hAAAA)  begin n_fail++; $display("[TB] FAIL zbuild_bypass_a actual=%h expected=aaaa", z_rda); end
    do_read(2'd1, 2'd2);
    n_checks++; if (nb_rda !== 16'hAAAA) begin n_fail++; $display("[TB] FAIL nobypass_after actual=%h expected=aaaa", nb_rda); end
  endtask

  task automatic test_zero_out_of_range();
    do_write(2'd0, 16'hFFFF);
    do_write(2'd3, 16'hABCD);
    do_read(2'd0, 2'd3);
    n_checks++; if (rda !== 16'hFFFF)   begin n_fail++; $display("[TB] FAIL plain_reg0 actual=%h expected=ffff", rda); end
    n_checks++; if (rdb !== 16'hABCD)   begin n_fail++; $display("[TB] FAIL plain_reg3 actual=%h expected=abcd", rdb); end
    n_checks++; if (z_rda !== 16'h0000) begin n_fail++; $display("[TB] FAIL zero_reg0 actual=%h expected=0000", z_rda); end
    n_checks++; if (z_rdb !== 16'h0000) begin n_fail++; $display("[TB] FAIL out_of_range actual=%h expected=0000", z_rdb); end
    WriteEnable = 1'b1; WriteSelect = 2'd0; WriteData = 16'h1234;
    ReadEnable  = 1'b1; ReadSelectA = 2'd0; ReadSelectB = 2'd3;
    tick();
    idle_inputs();
    n_checks++; if (rda !== 16'h1234)   begin n_fail++; $display("[TB] FAIL plain_bypass_reg0 actual=%h expected=1234", rda); end
    n_checks++; if (z_rda !== 16'h0000) begin n_fail++; $display("[TB] FAIL zero_no_bypass actual=%h expected=0000", z_rda); end
    n_checks++; if (z_rdb !== 16'h0000) begin n_fail++; $display("[TB] FAIL oor_no_bypass actual=%h expected=0000", z_rdb); end
  endtask

  task automatic test_clear();
    int cycles;
    do_write(2'd0, 16'h1111);
    do_write(2'd1, 16'h2222);
    do_write(2'd2, 16'h3333);
    do_write(2'd3, 16'h4444);
    ClearReq = 1'b1;
    tick();
    ClearReq = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 20) begin
      cycles++;
      idle_inputs();
      if (cycles == 3) begin
        WriteEnable = 1'b1; WriteSelect = 2'd1; WriteData = 16'h9999;
        ReadEnable  = 1'b1; ReadSelectA = 2'd1; ReadSelectB = 2'd2;
      end
      tick();
      if (cycles == 3) begin
        n_checks++; if (rv !== 1'b0)      begin n_fail++; $display("[TB] FAIL busy_read_valid actual=%b expected=0", rv); end
        n_checks++; if (rda !== 16'h1234) begin n_fail++; $display("[TB] FAIL busy_hold_a actual=%h expected=1234", rda); end
      end
    end
    idle_inputs();
    n_checks++; if (cycles !== 4) begin n_fail++; $display("[TB] FAIL clear_busy_cycles actual=%0d expected=4", cycles); end
    do_read(2'd0, 2'd1);
    n_checks++; if (rda !== 16'h0000) begin n_fail++; $display("[TB] FAIL clear_reg0 actual=%h expected=0000", rda); end
    n_checks++; if (rdb !== 16'h0000) begin n_fail++; $display("[TB] FAIL clear_reg1 actual=%h expected=0000", rdb); end
    n_checks++; if (rv !== 1'b1)      begin n_fail++; $display("[TB] FAIL clear_read_valid actual=%b expected=1", rv); end
    do_read(2'd2, 2'd3);
    n_checks++; if (rda !== 16'h0000) begin n_fail++; $display("[TB] FAIL clear_reg2 actual=%h expected=0000", rda); end
    n_checks++; if (rdb !== 16'h0000) begin n_fail++; $display("[TB] FAIL clear_reg3 actual=%h expected=0000", rdb); end
  endtask

  task automatic test_reset_mid_clear();
    int cycles;
    do_write(2'd2, 16'h7777);
    do_write(2'd3, 16'h7777);
    do_read(2'd2, 2'd3);
    ClearReq = 1'b1;
    tick();
    ClearReq = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL midclr_busy1 actual=%b expected=1", busy); end
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL midclr_busy2 actual=%b expected=1", busy); end
    RESET_N = 1'b0;
    #2;
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("[TB] FAIL midclr_reset_busy actual=%b expected=0", busy); end
    n_checks++; if (rda !== 16'h0000) begin n_fail++; $display("[TB] FAIL midclr_reset_rda actual=%h expected=0000", rda); end
    RESET_N = 1'b1;
    do_read(2'd2, 2'd3);
    n_checks++; if (rda !== 16'h0000) begin n_fail++; $display("[TB] FAIL midclr_reg2 actual=%h expected=0000", rda); end
    n_checks++; if (rdb !== 16'h0000) begin n_fail++; $display("[TB] FAIL midclr_reg3 actual=%h expected=0000", rdb); end
    n_checks++; if (rv !== 1'b1)      begin n_fail++; $display("[TB] FAIL midclr_valid actual=%b expected=1", rv); end
    ClearReq = 1'b1;
    tick();
    ClearReq = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 20) begin
      cycles++;
      tick();
    end
    n_checks++; if (cycles !== 4) begin n_fail++; $display("[TB] FAIL reclear_busy_cycles actual=%0d expected=4", cycles); end
  endtask

  task automatic test_back_to_back();
    int cycles;
    WriteEnable = 1'b1; WriteSelect = 2'd3; WriteData = 16'h5A5A;
    ReadEnable  = 1'b1; ReadSelectA = 2'd3; ReadSelectB = 2'd2;
    ClearReq    = 1'b1;
    tick();
    idle_inputs();
    n_checks++; if (busy !== 1'b1)       begin n_fail++; $display("[TB] FAIL b2b_busy actual=%b expected=1", busy); end
    n_checks++; if (rv !== 1'b1)         begin n_fail++; $display("[TB] FAIL b2b_valid actual=%b expected=1", rv); end
    n_checks++; if (rda !== 16'h5A5A)    begin n_fail++; $display("[TB] FAIL b2b_bypass_a actual=%h expected=5a5a", rda); end
    n_checks++; if (nb_rda !== 16'h0000) begin n_fail++; $display("[TB] FAIL b2b_nobypass_a actual=%h expected=0000", nb_rda); end
    cycles = 0;
    while (busy === 1'b1 && cycles < 20) begin
      cycles++;
      tick();
    end
    n_checks++; if (cycles !== 4) begin n_fail++; $display("[TB] FAIL b2b_busy_cycles actual=%0d expected=4", cycles); end
    do_read(2'd3, 2'd3);
    n_checks++; if (rda !== 16'h0000) begin n_fail++; $display("[TB] FAIL b2b_wiped actual=%h expected=0000", rda); end
    do_write(2'd0, 16'h0101);
    WriteEnable = 1'b1; WriteSelect = 2'd1; WriteData = 16'h0202;
    ReadEnable  = 1'b1; ReadSelectA = 2'd0; ReadSelectB = 2'd1;
    tick();
    idle_inputs();
    n_checks++; if (rda !== 16'h0101)    begin n_fail++; $display("[TB] FAIL b2b_read_a actual=%h expected=0101", rda); end
    n_checks++; if (rdb !== 16'h0202)    begin n_fail++; $display("[TB] FAIL b2b_read_b actual=%h expected=0202", rdb); end
    n_checks++; if (nb_rdb !== 16'h0000) begin n_fail++; $display("[TB] FAIL b2b_nobypass_b actual=%h expected=0000", nb_rdb); end
    n_checks++; if (z_rda !== 16'h0000)  begin n_fail++; $display("[TB] FAIL b2b_zero_a actual=%h expected=0000", z_rda); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_out_of_range();
    test_clear();
    test_reset_mid_clear();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_bank.md
# reg_file_bank

Parametrised CPU register file, successor to the fixed four-entry 16-bit register select. It holds DEPTH registers of WIDTH bits and has one synchronous write port and two registered read ports (A and B), with optional same-cycle write bypass and an optional hard-wired zero register. A clear sequencer wipes the bank one entry per cycle on request. It sits between the instruction decode stage and the ALU operand inputs.

## Interface
Parameters:
- WIDTH, 16, data width of each register.
- DEPTH, 4, number of registers; must be ≥2 and ≤2**ADDR_W.
- ADDR_W, 2, width of all select inputs.
- BYPASS, 1, when 1 a same-cycle write to the address being read returns the new data; when 0 it returns the old data.
- ZERO_REG0, 0, when 1 register 0 always reads 0 and writes to it are dropped.

Ports:
- CLK, input, 1, the single clock; all state updates on the rising edge.
- RESET_N, input, 1, reset; asynchronous, active-low.
- WriteEnable, input, 1, write request for this cycle.
- WriteSelect, input, ADDR_W, write address.
- WriteData, input, WIDTH, write data.
- ReadEnable, input, 1, samples both read selects this cycle.
- ReadSelectA, input, ADDR_W, port A read address.
- ReadSelectB, input, ADDR_W, port B read address.
- ReadDataA, output, WIDTH, registered port A data.
- ReadDataB, output, WIDTH, registered port B data.
- ReadValid, output, 1, pulses high for 1 cycle when ReadDataA/B were updated by an accepted read.
- ClearReq, input, 1, starts the clear sequence.
- Busy, output, 1, high while the clear sequence runs.

## Operation
- Storage: DEPTH × WIDTH flops. Any address ≥ DEPTH is out of range: a write to it is dropped, and a read from it returns 0.
- Write: if WriteEnable=1, Busy=0 and the address is valid, the register takes WriteData at the clock edge. If ZERO_REG0=1 and WriteSelect=0, the write is dropped.
- Read: accepted when ReadEnable=1 and Busy=0.
  - Each port latches its selected register into ReadDataA/B at the edge.
  - ReadValid is 1 the following cycle.
  - When no read is accepted, ReadDataA/B hold their last value and ReadValid=0.
- Bypass: a read and an accepted write to the same valid address in the same cycle return WriteData if BYPASS=1, else the pre-write value. Bypass never applies to a dropped write (zero register, out of range, or Busy).
- Zero register: with ZERO_REG0=1, reads of address 0 return 0.
- Clear state machine, two states:
  - IDLE: if ClearReq=1, go to CLEAR and set index=0.
  - CLEAR: clear register[index] to 0 and increment index. After clearing index DEPTH-1, return to IDLE. ClearReq is ignored while in CLEAR.
  - Busy = (state == CLEAR), registered.
- While Busy=1:
  - Writes are dropped.
  - Reads are not accepted: ReadValid=0 and the data outputs hold.

## Timing
- Reset (RESET_N=0, asynchronous, at any time, including mid-clear): all registers = 0, ReadDataA = ReadDataB = 0, ReadValid = 0, Busy = 0, state = IDLE, index = 0. Normal operation resumes on the first edge after RESET_N rises.
- Write latency: the value is visible to a read sampled on the next cycle (or the same cycle when BYPASS=1).
- Read latency: 1 cycle from the ReadEnable edge to ReadDataA/B and ReadValid.
- Clear sequence:
  - ClearReq sampled at edge t puts Busy high from t+1 through t+DEPTH.
  - Register k is zeroed at edge t+1+k.
  - Busy falls after edge t+DEPTH, so the first accepted read/write is at edge t+DEPTH+1.
- ClearReq in the same cycle as an accepted write or read: both are performed (Busy is still 0), and the written data is then wiped by the sequence.
- Port A and port B reading the same address is legal and returns identical data.

## Test plan
- Reset then read: RESET_N pulse, then ReadEnable with ReadSelectA=1, ReadSelectB=3 → ReadDataA = ReadDataB = 0x0000 and ReadValid=1 one cycle later.
- Write/read back: write 0xBEEF to reg 2 and 0x1234 to reg 3, then read A=2, B=3 → 0xBEEF/0x1234 with 1-cycle latency; outputs hold while ReadEnable=0.
- Bypass: same cycle write 0xAAAA to reg 1 and read A=1, with reg 1 previously 0x5555 → ReadDataA = 0xAAAA when BYPASS=1, 0x5555 when BYPASS=0.
- Zero register and out of range: ZERO_REG0=1 with write 0xFFFF to reg 0 → reads 0. DEPTH=3, ADDR_W=2: write to address 3 is dropped, and a read of address 3 returns 0.
- Clear: fill all 4 registers with nonzero values, pulse ClearReq → Busy high exactly 4 cycles. A write to reg 1 during Busy is dropped. All registers read 0 afterwards.
- Reset mid-clear: assert RESET_N=0 on the 2nd Busy cycle → Busy=0 immediately and all registers 0. A subsequent ClearReq runs the full DEPTH-cycle sequence.
